// File: rtl/srf_read_arbiter.sv
// Round-robin arbiter for the single SRF read port: grants one requester an
// exclusive burst of req_len beats, then rotates priority from the last winner.
module srf_read_arbiter #(
    parameter int NUM_REQ       = 3,
    parameter int NUM_STREAM_ID = 5,
    parameter int VLEN_WIDTH    = 5
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [NUM_REQ-1:0]                       req,
    input  logic [NUM_REQ-1:0][NUM_STREAM_ID-1:0]    req_stream,
    input  logic [NUM_REQ-1:0][VLEN_WIDTH-1:0]       req_len,
    output logic [NUM_REQ-1:0]                       gnt,
    output logic                                     srf_read_enable,
    output logic [NUM_STREAM_ID-1:0]                 stream_src1,
    output logic [VLEN_WIDTH-1:0]                    beat_idx,
    output logic                                     last_beat,
    output logic                                     busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W-1:0]      PTR_RST = PTR_W'(NUM_REQ - 1);
    localparam logic [VLEN_WIDTH-1:0] ONE_V   = VLEN_WIDTH'(1'b1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t                      state_r;
    state_t                      state_nxt_s;
    logic [PTR_W-1:0]            ptr_r;
    logic [PTR_W-1:0]            ptr_nxt_s;
    logic [VLEN_WIDTH-1:0]       len_r;
    logic [VLEN_WIDTH-1:0]       len_nxt_s;
    logic [NUM_REQ-1:0]          gnt_nxt_s;
    logic                        en_nxt_s;
    logic [NUM_STREAM_ID-1:0]    stream_nxt_s;
    logic [VLEN_WIDTH-1:0]       beat_nxt_s;
    logic                        last_nxt_s;
    logic                        busy_nxt_s;
    logic                        win_found_s;
    logic [PTR_W-1:0]            win_idx_s;
    logic [PTR_W-1:0]            cand_s;
    logic [VLEN_WIDTH-1:0]       beat_inc_s;

    // Rotating search: first set request after ptr, wrapping, ptr itself last.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
        cand_s      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_s = PTR_W'((int'(ptr_r) + k) % NUM_REQ);
            if (!win_found_s && req[cand_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_s;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_nxt_s  = state_r;
        ptr_nxt_s    = ptr_r;
        len_nxt_s    = len_r;
        gnt_nxt_s    = '0;
        en_nxt_s     = 1'b0;
        stream_nxt_s = stream_src1;
        beat_nxt_s   = '0;
        last_nxt_s   = 1'b0;
        busy_nxt_s   = 1'b0;
        beat_inc_s   = beat_idx + ONE_V;
        case (state_r)
            IDLE: begin
                if (win_found_s) begin
                    state_nxt_s            = BURST;
                    ptr_nxt_s              = win_idx_s;
                    gnt_nxt_s[win_idx_s]   = 1'b1;
                    en_nxt_s               = 1'b1;
                    busy_nxt_s             = 1'b1;
                    stream_nxt_s           = req_stream[win_idx_s];
                    len_nxt_s              = req_len[win_idx_s];
                    // len of 1 ends on beat 0; len of 0 wraps to a full burst
                    last_nxt_s             = (req_len[win_idx_s] == ONE_V);
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BURST: begin
                if (last_beat) begin
                    state_nxt_s = IDLE;
                end else begin
                    gnt_nxt_s  = gnt;
                    en_nxt_s   = 1'b1;
                    busy_nxt_s = 1'b1;
                    beat_nxt_s = beat_inc_s;
                    last_nxt_s = (beat_inc_s == (len_r - ONE_V));
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, pointer and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= IDLE;
            ptr_r           <= PTR_RST;
            len_r           <= '0;
            gnt             <= '0;
            srf_read_enable <= 1'b0;
            stream_src1     <= '0;
            beat_idx        <= '0;
            last_beat       <= 1'b0;
            busy            <= 1'b0;
        end else begin
            state_r         <= state_nxt_s;
            ptr_r           <= ptr_nxt_s;
            len_r           <= len_nxt_s;
            gnt             <= gnt_nxt_s;
            srf_read_enable <= en_nxt_s;
            stream_src1     <= stream_nxt_s;
            beat_idx        <= beat_nxt_s;
            last_beat       <= last_nxt_s;
            busy            <= busy_nxt_s;
        end
    end

endmodule

// File: tb/tb_srf_read_arbiter.sv
// Directed self-checking bench for srf_read_arbiter (3 requesters, 5-bit len).
module tb_srf_read_arbiter;

    logic                 clk;
    logic                 rst;
    logic [2:0]           req;
    logic [2:0][4:0]      req_stream;
    logic [2:0][4:0]      req_len;
    logic [2:0]           gnt;
    logic                 srf_read_enable;
    logic [4:0]           stream_src1;
    logic [4:0]           beat_idx;
    logic                 last_beat;
    logic                 busy;

    int checks_cnt = 0;
    int errors_cnt = 0;

    srf_read_arbiter #(.NUM_REQ(3), .NUM_STREAM_ID(5), .VLEN_WIDTH(5)) dut (
        .clk(clk), .rst(rst), .req(req), .req_stream(req_stream), .req_len(req_len),
        .gnt(gnt), .srf_read_enable(srf_read_enable), .stream_src1(stream_src1),
        .beat_idx(beat_idx), .last_beat(last_beat), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_beat(input string tag, input logic [2:0] g, input logic [4:0] s,
                            input logic [4:0] b, input logic l);
        chk({tag, " gnt"}, 32'(gnt), 32'(g));
        chk({tag, " en"}, 32'(srf_read_enable), 32'(1'b1));
        chk({tag, " busy"}, 32'(busy), 32'(1'b1));
        chk({tag, " stream"}, 32'(stream_src1), 32'(s));
        chk({tag, " beat"}, 32'(beat_idx), 32'(b));
        chk({tag, " last"}, 32'(last_beat), 32'(l));
    endtask

    task automatic chk_idle(input string tag, input logic [4:0] s);
        chk({tag, " gnt"}, 32'(gnt), 32'h0);
        chk({tag, " en"}, 32'(srf_read_enable), 32'h0);
        chk({tag, " busy"}, 32'(busy), 32'h0);
        chk({tag, " stream"}, 32'(stream_src1), 32'(s));
        chk({tag, " beat"}, 32'(beat_idx), 32'h0);
        chk({tag, " last"}, 32'(last_beat), 32'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [2:0] order [6];
        order = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        rst = 1'b1;
        req = 3'b000;
        req_stream = '0;
        req_len = '0;
        do_reset();
        chk_idle("reset", 5'd0);

        // single 3-beat burst from requester 0
        req = 3'b001;
        req_len[0] = 5'd3;
        req_stream[0] = 5'd7;
        for (int i = 0; i < 3; i++) begin
            step();
            req = 3'b000;
            chk_beat("t1", 3'b001, 5'd7, 5'(i), (i == 2));
        end
        step();
        chk_idle("t1 idle", 5'd7);

        // fair rotation, all requesters held high
        do_reset();
        req_stream[0] = 5'd1; req_stream[1] = 5'd2; req_stream[2] = 5'd3;
        req_len[0] = 5'd2; req_len[1] = 5'd2; req_len[2] = 5'd2;
        req = 3'b111;
        for (int n = 0; n < 6; n++) begin
            logic [4:0] s;
            s = (order[n] == 3'b001) ? 5'd1 : ((order[n] == 3'b010) ? 5'd2 : 5'd3);
            step();
            chk_beat("rr b0", order[n], s, 5'd0, 1'b0);
            step();
            chk_beat("rr b1", order[n], s, 5'd1, 1'b1);
            step();
            if (n == 5) req = 3'b010;
            chk_idle("rr idle", s);
        end

        // len 0 on requester 1: full 32-beat burst
        req_len[1] = 5'd0;
        for (int i = 0; i < 32; i++) begin
            step();
            req = 3'b000;
            chk_beat("full", 3'b010, 5'd2, 5'(i), (i == 31));
        end
        step();
        chk_idle("full idle", 5'd2);

        // inputs changed mid-burst are ignored; req 2 wins next by rotation
        req = 3'b001;
        req_len[0] = 5'd4;
        req_stream[0] = 5'd9;
        req_stream[2] = 5'd5;
        req_len[2] = 5'd2;
        step();
        chk_beat("own b0", 3'b001, 5'd9, 5'd0, 1'b0);
        req_stream[0] = 5'd20;
        req_len[0] = 5'd1;
        req = 3'b101;
        for (int i = 1; i < 4; i++) begin
            step();
            chk_beat("own", 3'b001, 5'd9, 5'(i), (i == 3));
        end
        step();
        chk_idle("own idle", 5'd9);
        step();
        chk_beat("rot win", 3'b100, 5'd5, 5'd0, 1'b0);

        // requester 2 alone: back-to-back re-grant with one idle cycle
        req = 3'b100;
        step();
        chk_beat("solo b1", 3'b100, 5'd5, 5'd1, 1'b1);
        step();
        chk_idle("solo idle", 5'd5);
        step();
        chk_beat("regrant b0", 3'b100, 5'd5, 5'd0, 1'b0);
        step();
        chk_beat("regrant b1", 3'b100, 5'd5, 5'd1, 1'b1);
        req = 3'b000;
        step();
        chk_idle("regrant idle", 5'd5);

        // reset mid-burst, then ptr restarts at requester 0
        req = 3'b001;
        req_len[0] = 5'd8;
        req_stream[0] = 5'd11;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_beat("pre rst", 3'b001, 5'd11, 5'(i), 1'b0);
        end
        rst = 1'b1;
        req = 3'b111;
        step();
        chk_idle("mid rst", 5'd0);
        rst = 1'b0;
        step();
        chk_beat("post rst", 3'b001, 5'd11, 5'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule

// File: doc/srf_read_arbiter.md
# srf_read_arbiter

Round-robin arbiter sharing the single SRF read port among several requesters: instruction dispatch, the VXM operand path and the memory write-back path. A requester asks for a stream and a vector length. The winner gets exclusive use of the read port for a burst of that many consecutive beats, one tile-slice vector per beat. The block drives the SRF read enable and stream select, and returns per-beat and last-beat strobes to the owner.

## Interface
Parameters:
- NUM_REQ, 3, number of requesters (≥2)
- NUM_STREAM_ID, 5, stream-id width
- VLEN_WIDTH, 5, vector-length / beat-index width

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high, one clock domain
- req  in  NUM_REQ  level request per requester
- req_stream  in  NUM_REQ×NUM_STREAM_ID (packed, requester i at [i])  stream to read
- req_len  in  NUM_REQ×VLEN_WIDTH (packed)  burst length in beats; 0 means 2^VLEN_WIDTH
- gnt  out  NUM_REQ  one-hot owner of current burst; all-zero when idle
- srf_read_enable  out  1  high on every burst beat
- stream_src1  out  NUM_STREAM_ID  latched stream of the current owner
- beat_idx  out  VLEN_WIDTH  beat number within burst, 0-based
- last_beat  out  1  high on the final beat of a burst
- busy  out  1  high while in BURST

## Operation
- States are IDLE and BURST. Reset enters IDLE.
- Round-robin pointer ptr holds the index of the last granted requester. Reset value is NUM_REQ-1, so req[0] has top priority after reset.
- In IDLE, at each clock edge, the arbiter samples req:
  - If no bit is set, it stays in IDLE.
  - Otherwise, it selects the first set bit searching ptr+1, ptr+2, … modulo NUM_REQ.
  - For the winner w, it registers gnt=onehot(w), stream_src1=req_stream[w], len=req_len[w], beat_idx=0, ptr=w, and enters BURST.
- In BURST:
  - srf_read_enable=1, busy=1 and gnt is held.
  - beat_idx increments by 1 each cycle.
  - last_beat=1 when beat_idx == len-1, computed modulo 2^VLEN_WIDTH. len=0 therefore yields a full 2^VLEN_WIDTH-beat burst ending at beat_idx all-ones.
  - On the last_beat cycle the next state is IDLE.
- req_stream, req_len and req are ignored during BURST. Changes made by the owner or by others have no effect until the next arbitration.
- There is no abort. A burst always runs to completion unless rst is asserted.
- Requester contract: after observing last_beat, a requester with no further work deasserts req starting the following cycle, which is the mandatory IDLE cycle. If it keeps req high, it competes again.
- If the previous owner is the only requester still asserting req, it is re-granted. Otherwise any other requester wins by rotation.
- When a burst ends, stream_src1 keeps its last value. All other outputs return to 0 in IDLE.

## Timing
- All outputs are registered.
- Reset values: gnt=0, srf_read_enable=0, stream_src1=0, beat_idx=0, last_beat=0, busy=0, ptr=NUM_REQ-1, state=IDLE.
- rst in any cycle, including mid-burst, forces the reset values on the next edge. A pending burst is discarded.
- Latency: req high in IDLE cycle T gives the first beat (gnt, srf_read_enable, beat_idx=0) in cycle T+1.
- A burst of L beats occupies T+1..T+L, with last_beat at T+L and IDLE at T+L+1. The next burst starts no earlier than T+L+2, giving throughput L/(L+1).
- Simultaneous requests arriving in the same IDLE cycle are resolved purely by rotation order from ptr.
- The arbiter is fair: with all NUM_REQ requesters continuously asserting, each is granted exactly once per NUM_REQ bursts.

## Test plan
- Reset, then req=001, req_len[0]=3, stream 7:
  - Cycles 1–3 show gnt=001, srf_read_enable=1, stream_src1=7, beat_idx=0,1,2.
  - last_beat appears only at beat_idx 2.
  - Cycle 4 is IDLE with all strobes 0.
- All three requesters held high, each with len=2 → grant order 0,1,2,0,1,2. Each burst is 2 beats with one IDLE cycle between bursts.
- req_len=0 on requester 1 alone → 32-beat burst, beat_idx 0..31, last_beat at 31.
- During requester 0's burst, change req_stream[0] and req_len[0], and raise req[2]:
  - The current burst is unaffected.
  - Requester 2 wins in the next IDLE, even though req[0] is still high.
- Requester 2 is the sole requester, holding req continuously → it is re-granted back-to-back, with exactly one IDLE cycle between bursts.
- Assert rst at beat 4 of an 8-beat burst:
  - The next cycle has all outputs 0.
  - ptr is reset: with req=111 afterwards, requester 0 is granted first.
